ps2_key_encoder: RTL and testbench



---
 rtl/ps2_key_encoder.sv | 151 +++++++++++++++
 tb/tb_ps2_key_encoder.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/ps2_key_encoder.sv
// PS/2 keyboard front-end: synchronises and filters the raw PS/2 lines, deserialises
// device-to-host frames and folds E0/F0 prefixes into one toggle-strobed event word.
module ps2_key_encoder #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 96000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ps2_clk_i,
  input  logic        ps2_data_i,
  output logic [10:0] ps2_key,
  output logic        frame_err,
  output logic        busy
);

  localparam logic [7:0]  FILTER_MAX  = 8'(FILTER_LEN - 1);
  localparam logic [16:0] TIMEOUT_VAL = 17'(TIMEOUT_CYCLES);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } frame_state_t;

  logic         clk_s1, clk_s2;
  logic         data_s1, data_s2;
  logic         clk_filt;
  logic [7:0]   hold_cnt;
  logic         fall_edge;

  frame_state_t state;
  logic [3:0]   bit_cnt;
  logic [7:0]   shift_reg;
  logic         parity_bit;
  logic [16:0]  timeout_cnt;
  logic         ext_flag;
  logic         brk_flag;
  logic         frame_ok;

  // Synchronisers reset to the idle-high line level so release from reset
  // never looks like a falling edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_s1  <= 1'b1;
      clk_s2  <= 1'b1;
      data_s1 <= 1'b1;
      data_s2 <= 1'b1;
    end else begin
      clk_s1  <= ps2_clk_i;
      clk_s2  <= clk_s1;
      data_s1 <= ps2_data_i;
      data_s2 <= data_s1;
    end
  end

  // The filtered clock only follows the synchronised clock once it has
  // disagreed for FILTER_LEN consecutive cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_filt <= 1'b1;
      hold_cnt <= 8'd0;
    end else if (clk_s2 == clk_filt) begin
      hold_cnt <= 8'd0;
    end else if (hold_cnt == FILTER_MAX) begin
      clk_filt <= clk_s2;
      hold_cnt <= 8'd0;
    end else begin
      hold_cnt <= hold_cnt + 8'd1;
    end
  end

  assign fall_edge = clk_filt && !clk_s2 && (hold_cnt == FILTER_MAX);

  // Odd parity across data plus parity bit, and the stop bit being sampled now.
  assign frame_ok = (^{shift_reg, parity_bit}) && data_s2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      bit_cnt     <= 4'd0;
      shift_reg   <= 8'd0;
      parity_bit  <= 1'b0;
      timeout_cnt <= 17'd0;
      ext_flag    <= 1'b0;
      brk_flag    <= 1'b0;
      ps2_key     <= 11'd0;
      frame_err   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          timeout_cnt <= 17'd0;
          if (fall_edge) begin
            if (!data_s2) begin
              state   <= SHIFT;
              bit_cnt <= 4'd1;
              busy    <= 1'b1;
            end else begin
              frame_err <= 1'b1;
              ext_flag  <= 1'b0;
              brk_flag  <= 1'b0;
            end
          end
        end

        SHIFT: begin
          if (fall_edge) begin
            timeout_cnt <= 17'd0;
            if (bit_cnt <= 4'd8) begin
              shift_reg <= {data_s2, shift_reg[7:1]};
              bit_cnt   <= bit_cnt + 4'd1;
            end else if (bit_cnt == 4'd9) begin
              parity_bit <= data_s2;
              bit_cnt    <= 4'd10;
            end else begin
              state   <= IDLE;
              bit_cnt <= 4'd0;
              busy    <= 1'b0;
              if (!frame_ok) begin
                frame_err <= 1'b1;
                ext_flag  <= 1'b0;
                brk_flag  <= 1'b0;
              end else if (shift_reg == 8'hE0) begin
                ext_flag <= 1'b1;
              end else if (shift_reg == 8'hF0) begin
                brk_flag <= 1'b1;
              end else begin
                ps2_key  <= {~ps2_key[10], ~brk_flag, ext_flag, shift_reg};
                ext_flag <= 1'b0;
                brk_flag <= 1'b0;
              end
            end
          end else if (timeout_cnt == TIMEOUT_VAL) begin
            state       <= IDLE;
            bit_cnt     <= 4'd0;
            busy        <= 1'b0;
            timeout_cnt <= 17'd0;
            frame_err   <= 1'b1;
            ext_flag    <= 1'b0;
            brk_flag    <= 1'b0;
          end else begin
            timeout_cnt <= timeout_cnt + 17'd1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_key_encoder.sv
// Directed bench for ps2_key_encoder: drives PS/2 frames on the raw lines and
// checks event words, error pulses and busy against hand-computed values.
module tb_ps2_key_encoder;

  localparam int FILTER_LEN = 8;
  localparam int TIMEOUT    = 1000;
  localparam int HALF       = 40;

  logic        clk;
  logic        reset_n;
  logic        ps2_clk_i;
  logic        ps2_data_i;
  logic [10:0] ps2_key;
  logic        frame_err;
  logic        busy;

  int checks;
  int failures;
  int toggles;
  int err_pulses;
  logic prev_strobe;

  ps2_key_encoder #(
    .FILTER_LEN(FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .ps2_clk_i(ps2_clk_i),
    .ps2_data_i(ps2_data_i),
    .ps2_key(ps2_key),
    .frame_err(frame_err),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Strobe toggles and error pulses are tallied independently of the DUT state.
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_strobe <= 1'b0;
    end else begin
      if (ps2_key[10] !== prev_strobe) toggles++;
      prev_strobe <= ps2_key[10];
      if (frame_err === 1'b1) begin
        err_pulses++;
        checkOutput("busy_low_on_err", {31'd0, busy}, 32'd0);
      end
    end
  end

  // Sends the first nbits bits of a frame (start, 8 data LSB first, parity, stop).
  task automatic applyStimulus(input logic [7:0] code, input logic flip_parity, input int nbits);
    logic [10:0] frame;
    frame = {1'b1, (~^code) ^ flip_parity, code, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data_i = frame[i];
      repeat (HALF) @(posedge clk);
      ps2_clk_i = 1'b0;
      repeat (HALF) @(posedge clk);
      ps2_clk_i = 1'b1;
    end
    ps2_data_i = 1'b1;
    repeat (HALF) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    toggles     = 0;
    err_pulses  = 0;
    prev_strobe = 1'b0;
    reset_n     = 1'b0;
    ps2_clk_i   = 1'b1;
    ps2_data_i  = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_key", {21'd0, ps2_key}, 32'h0);
    checkOutput("reset_err", {31'd0, frame_err}, 32'd0);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    reset_n = 1'b1;
    repeat (5) @(posedge clk);

    // Plain make code
    applyStimulus(8'h1C, 1'b0, 11);
    checkOutput("make_1C", {21'd0, ps2_key}, 32'h61C);
    checkOutput("make_1C_toggles", toggles, 1);
    checkOutput("make_1C_errs", err_pulses, 0);

    // Extended break sequence, then flags must be clear again
    applyStimulus(8'hE0, 1'b0, 11);
    checkOutput("e0_no_event", toggles, 1);
    applyStimulus(8'hF0, 1'b0, 11);
    checkOutput("f0_no_event", toggles, 1);
    applyStimulus(8'h75, 1'b0, 11);
    checkOutput("ext_break_75", {21'd0, ps2_key}, 32'h175);
    checkOutput("ext_break_toggles", toggles, 2);
    applyStimulus(8'h1C, 1'b0, 11);
    checkOutput("flags_cleared", {21'd0, ps2_key}, 32'h61C);
    checkOutput("flags_cleared_toggles", toggles, 3);

    // Bad parity
    applyStimulus(8'h1C, 1'b1, 11);
    checkOutput("parity_err_count", err_pulses, 1);
    checkOutput("parity_key_held", {21'd0, ps2_key}, 32'h61C);
    checkOutput("parity_busy", {31'd0, busy}, 32'd0);
    checkOutput("parity_toggles", toggles, 3);

    // Short clock glitch with data low must not start a frame
    ps2_data_i = 1'b0;
    repeat (10) @(posedge clk);
    ps2_clk_i = 1'b0;
    repeat (5) @(posedge clk);
    ps2_clk_i = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (busy !== 1'b0) break;
    end
    checkOutput("glitch_busy", {31'd0, busy}, 32'd0);
    checkOutput("glitch_errs", err_pulses, 1);
    ps2_data_i = 1'b1;
    repeat (10) @(posedge clk);
    applyStimulus(8'h1C, 1'b0, 11);
    checkOutput("after_glitch", {21'd0, ps2_key}, 32'h21C);

    // Timeout after start plus four data bits
    applyStimulus(8'h33, 1'b0, 5);
    checkOutput("partial_busy", {31'd0, busy}, 32'd1);
    repeat (TIMEOUT + 10) @(posedge clk);
    @(negedge clk);
    checkOutput("timeout_errs", err_pulses, 2);
    checkOutput("timeout_busy", {31'd0, busy}, 32'd0);
    applyStimulus(8'h29, 1'b0, 11);
    checkOutput("after_timeout", {21'd0, ps2_key}, 32'h629);
    checkOutput("after_timeout_toggles", toggles, 5);

    // Asynchronous reset mid-frame
    applyStimulus(8'h1C, 1'b0, 6);
    checkOutput("midframe_busy", {31'd0, busy}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("async_key", {21'd0, ps2_key}, 32'h0);
    checkOutput("async_busy", {31'd0, busy}, 32'd0);
    checkOutput("async_err", {31'd0, frame_err}, 32'd0);
    repeat (5) @(posedge clk);
    reset_n = 1'b1;
    repeat (5) @(posedge clk);
    applyStimulus(8'h1C, 1'b0, 11);
    checkOutput("after_reset", {21'd0, ps2_key}, 32'h61C);
    checkOutput("final_errs", err_pulses, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
